iter_muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit. Sits beside the single-cycle ALU in the execute stage; the control unit steers the funct7=0000001 R-type instructions here.
- Radix-2 iterative datapath with a valid/ready handshake on both sides and a flush input. The core stalls while the unit is busy.
- Parametrised in operand width and in early-out for special cases.

---
 rtl/iter_muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up and a valid/ready handshake.
module iter_muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [2:0]        op_q;
  logic              neg_q;
  logic              neg_r;
  logic              special_q;
  logic [XLEN-1:0]   special_res_q;
  logic [XLEN-1:0]   addend_q;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     count;

  logic              accept;
  logic              a_signed_in, b_signed_in;
  logic              sa_in, sb_in;
  logic [XLEN-1:0]   abs_a_in, abs_b_in;
  logic              div0_in, ovf_in, special_in, fast_in;
  logic [XLEN-1:0]   special_res_in;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] iter_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;

  // Request decode: signedness per funct3, magnitudes and the two special divides.
  always_comb begin
    a_signed_in    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_in    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa_in          = a_signed_in && op_a[XLEN-1];
    sb_in          = b_signed_in && op_b[XLEN-1];
    abs_a_in       = sa_in ? -op_a : op_a;
    abs_b_in       = sb_in ? -op_b : op_b;
    div0_in        = funct3[2] && (op_b == '0);
    ovf_in         = funct3[2] && !funct3[0] &&
                     (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special_in     = div0_in || ovf_in;
    special_res_in = div0_in ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
    fast_in        = SPECIAL_FAST && special_in;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = fast_in ? DONE : CALC;
      CALC: if (count == CW'(XLEN - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // One radix-2 step; acc is {product high, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & addend_q};
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, addend_q};
    div_ok    = !div_trial[XLEN];
    div_rem   = div_ok ? div_trial[XLEN-1:0] : acc[2*XLEN-2:XLEN-1];
    iter_next = op_q[2] ? {div_rem, acc[XLEN-2:0], div_ok}
                        : {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (special_q)
      fix_res = special_res_q;
    else if (op_q[2])
      fix_res = op_q[1] ? rem_fix : quo_fix;
    else
      fix_res = (op_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      result        <= '0;
      op_q          <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      addend_q      <= '0;
      acc           <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q          <= funct3;
        neg_q         <= sa_in ^ sb_in;
        neg_r         <= sa_in;
        special_q     <= special_in;
        special_res_q <= special_res_in;
        addend_q      <= funct3[2] ? abs_b_in : abs_a_in;
        acc           <= {{XLEN{1'b0}}, funct3[2] ? abs_a_in : abs_b_in};
        count         <= '0;
        if (fast_in) result <= special_res_in;
      end else if (state == CALC && !flush) begin
        acc   <= iter_next;
        count <= count + CW'(1);
      end else if (state == FIX && !flush) begin
        result <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed checks of iter_muldiv_unit at XLEN=32 (fast and slow special paths)
// plus an XLEN=8 instance compared against an integer reference on random operands.
module tb_iter_muldiv_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  f3_32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        out_ready32 = 1'b1, flush32 = 1'b0;
  logic        f_in_valid = 1'b0, s_in_valid = 1'b0;
  logic        f_in_ready, f_out_valid, f_busy;
  logic        s_in_ready, s_out_valid, s_busy;
  logic [31:0] f_result, s_result;

  logic [2:0]  f3_8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        e_in_valid = 1'b0, out_ready8 = 1'b1, flush8 = 1'b0;
  logic        e_in_ready, e_out_valid, e_busy;
  logic [7:0]  e_result;

  int total = 0;
  int bad = 0;

  iter_muldiv_unit #(.XLEN(32), .SPECIAL_FAST(1'b1)) u_fast (
    .clk(clk), .reset(reset), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .funct3(f3_32), .op_a(a32), .op_b(b32), .flush(flush32),
    .out_valid(f_out_valid), .out_ready(out_ready32), .result(f_result), .busy(f_busy));

  iter_muldiv_unit #(.XLEN(32), .SPECIAL_FAST(1'b0)) u_slow (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .funct3(f3_32), .op_a(a32), .op_b(b32), .flush(flush32),
    .out_valid(s_out_valid), .out_ready(out_ready32), .result(s_result), .busy(s_busy));

  iter_muldiv_unit #(.XLEN(8), .SPECIAL_FAST(1'b1)) u_small (
    .clk(clk), .reset(reset), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .funct3(f3_8), .op_a(a8), .op_b(b8), .flush(flush8),
    .out_valid(e_out_valid), .out_ready(out_ready8), .result(e_result), .busy(e_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat = edges after the accept edge until out_valid is seen; hs_bad flags handshake violations.
  task automatic do_op(input bit slow, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat,
                       output bit hs_bad);
    f3_32 = f3; a32 = a; b32 = b; out_ready32 = 1'b1;
    hs_bad = 1'b0;
    if (slow) s_in_valid = 1'b1; else f_in_valid = 1'b1;
    if (!(slow ? s_in_ready : f_in_ready)) hs_bad = 1'b1;
    tick();
    s_in_valid = 1'b0; f_in_valid = 1'b0;
    lat = 0;
    while (!(slow ? s_out_valid : f_out_valid) && lat < 200) begin
      if ((slow ? s_in_ready : f_in_ready) || !(slow ? s_busy : f_busy)) hs_bad = 1'b1;
      tick();
      lat++;
    end
    if (slow ? s_in_ready : f_in_ready) hs_bad = 1'b1;
    res = slow ? s_result : f_result;
    tick();
  endtask

  task automatic do_op8(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
    f3_8 = f3; a8 = a; b8 = b; out_ready8 = 1'b1;
    e_in_valid = 1'b1;
    tick();
    e_in_valid = 1'b0;
    lat = 0;
    while (!e_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    res = e_result;
    tick();
  endtask

  function automatic logic [7:0] ref8(input logic [2:0] f3, input logic [7:0] a,
                                      input logic [7:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {56'd0, a};
    ub = {56'd0, b};
    p = 0;
    case (f3)
      3'b000: begin p = ua * ub; return p[7:0]; end
      3'b001: begin p = sa * sb; return p[15:8]; end
      3'b010: begin p = sa * ub; return p[15:8]; end
      3'b011: begin p = ua * ub; return p[15:8]; end
      3'b100: begin if (b == 8'h00) return 8'hFF; p = sa / sb; return p[7:0]; end
      3'b101: begin if (b == 8'h00) return 8'hFF; p = ua / ub; return p[7:0]; end
      3'b110: begin if (b == 8'h00) return a; p = sa % sb; return p[7:0]; end
      default: begin if (b == 8'h00) return a; p = ua % ub; return p[7:0]; end
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (f_in_ready !== 1'b1 || f_out_valid !== 1'b0 || f_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_fast_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0",
               f_in_ready, f_out_valid, f_busy);
    end
    total++;
    if (f_result !== 32'h0 || s_result !== 32'h0 || e_result !== 8'h0) begin
      bad++;
      $display("[TB] FAIL reset_result: fast=%h slow=%h small=%h required 0", f_result, s_result, e_result);
    end
    total++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_slow_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0",
               s_in_ready, s_out_valid, s_busy);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    bit hs;
    do_op(1'b0, 3'b000, 32'd7, 32'hFFFFFFFD, r, lat, hs);
    total++;
    if (r !== 32'hFFFFFFEB) begin bad++; $display("[TB] FAIL mul_7x-3: got %h required ffffffeb", r); end
    total++;
    if (lat !== 33) begin bad++; $display("[TB] FAIL mul_latency: got %0d required 33", lat); end
    total++;
    if (hs !== 1'b0) begin bad++; $display("[TB] FAIL mul_handshake: violation flag %b required 0", hs); end
    total++;
    if (f_busy !== 1'b0 || f_in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mul_consumed: busy=%b in_ready=%b required 0 1", f_busy, f_in_ready);
    end
    do_op(1'b0, 3'b001, 32'h80000000, 32'h80000000, r, lat, hs);
    total++;
    if (r !== 32'h40000000) begin bad++; $display("[TB] FAIL mulh_min: got %h required 40000000", r); end
    do_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, hs);
    total++;
    if (r !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL mulhsu_ones: got %h required ffffffff", r); end
    do_op(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, hs);
    total++;
    if (r !== 32'hFFFFFFFE) begin bad++; $display("[TB] FAIL mulhu_ones: got %h required fffffffe", r); end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    bit hs;
    do_op(1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, hs);
    total++;
    if (r !== 32'h80000000 || lat !== 0) begin
      bad++; $display("[TB] FAIL div_ovf_fast: got %h lat %0d required 80000000 lat 0", r, lat);
    end
    do_op(1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, hs);
    total++;
    if (r !== 32'h0) begin bad++; $display("[TB] FAIL rem_ovf_fast: got %h required 0", r); end
    do_op(1'b1, 3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, hs);
    total++;
    if (r !== 32'h80000000 || lat !== 33) begin
      bad++; $display("[TB] FAIL div_ovf_slow: got %h lat %0d required 80000000 lat 33", r, lat);
    end
    do_op(1'b0, 3'b100, 32'd5, 32'd0, r, lat, hs);
    total++;
    if (r !== 32'hFFFFFFFF || lat !== 0) begin
      bad++; $display("[TB] FAIL div0_fast: got %h lat %0d required ffffffff lat 0", r, lat);
    end
    do_op(1'b1, 3'b100, 32'd5, 32'd0, r, lat, hs);
    total++;
    if (r !== 32'hFFFFFFFF || lat !== 33) begin
      bad++; $display("[TB] FAIL div0_slow: got %h lat %0d required ffffffff lat 33", r, lat);
    end
    do_op(1'b0, 3'b111, 32'd5, 32'd0, r, lat, hs);
    total++;
    if (r !== 32'd5 || lat !== 0) begin
      bad++; $display("[TB] FAIL remu0_fast: got %h lat %0d required 5 lat 0", r, lat);
    end
    do_op(1'b1, 3'b111, 32'd5, 32'd0, r, lat, hs);
    total++;
    if (r !== 32'd5 || lat !== 33) begin
      bad++; $display("[TB] FAIL remu0_slow: got %h lat %0d required 5 lat 33", r, lat);
    end
    do_op(1'b1, 3'b110, 32'hFFFFFFF9, 32'd0, r, lat, hs);
    total++;
    if (r !== 32'hFFFFFFF9) begin bad++; $display("[TB] FAIL rem0_neg_slow: got %h required fffffff9", r); end
    do_op(1'b0, 3'b110, 32'hFFFFFFF9, 32'd2, r, lat, hs);
    total++;
    if (r !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL rem_-7_2: got %h required ffffffff", r); end
    do_op(1'b0, 3'b100, 32'hFFFFFFF9, 32'd2, r, lat, hs);
    total++;
    if (r !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL div_-7_2: got %h required fffffffd", r); end
    do_op(1'b0, 3'b101, 32'd100, 32'd7, r, lat, hs);
    total++;
    if (r !== 32'd14) begin bad++; $display("[TB] FAIL divu_100_7: got %h required e", r); end
    do_op(1'b0, 3'b111, 32'd100, 32'd7, r, lat, hs);
    total++;
    if (r !== 32'd2) begin bad++; $display("[TB] FAIL remu_100_7: got %h required 2", r); end
    total++;
    if (hs !== 1'b0) begin bad++; $display("[TB] FAIL div_handshake: violation flag %b required 0", hs); end
  endtask

  task automatic test_back_to_back();
    int lat;
    f3_32 = 3'b000; a32 = 32'd3; b32 = 32'd4; out_ready32 = 1'b0;
    f_in_valid = 1'b1;
    tick();
    f_in_valid = 1'b0;
    lat = 0;
    while (!f_out_valid && lat < 100) begin tick(); lat++; end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (f_out_valid !== 1'b1 || f_result !== 32'd12 || f_in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold_cycle_%0d: out_valid=%b result=%h in_ready=%b required 1 0000000c 0",
                 i, f_out_valid, f_result, f_in_ready);
      end
      tick();
    end
    out_ready32 = 1'b1;
    a32 = 32'd5; b32 = 32'd6;
    f_in_valid = 1'b1;
    tick();
    total++;
    if (f_busy !== 1'b0 || f_in_ready !== 1'b1 || f_out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL consume_edge: busy=%b in_ready=%b out_valid=%b required 0 1 0",
               f_busy, f_in_ready, f_out_valid);
    end
    tick();
    f_in_valid = 1'b0;
    total++;
    if (f_busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept: busy=%b required 1", f_busy); end
    lat = 0;
    while (!f_out_valid && lat < 100) begin tick(); lat++; end
    total++;
    if (f_result !== 32'd30 || lat !== 33) begin
      bad++; $display("[TB] FAIL b2b_result: got %h lat %0d required 1e lat 33", f_result, lat);
    end
    tick();
  endtask

  task automatic test_flush();
    int seen;
    f3_32 = 3'b100; a32 = 32'd100; b32 = 32'd7; out_ready32 = 1'b1;
    f_in_valid = 1'b1;
    tick();
    f_in_valid = 1'b0;
    repeat (10) tick();
    flush32 = 1'b1;
    f_in_valid = 1'b1;
    tick();
    total++;
    if (f_busy !== 1'b0 || f_out_valid !== 1'b0 || f_in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_idle: busy=%b out_valid=%b in_ready=%b required 0 0 1",
               f_busy, f_out_valid, f_in_ready);
    end
    tick();
    total++;
    if (f_busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_priority: busy=%b required 0", f_busy); end
    flush32 = 1'b0;
    f_in_valid = 1'b0;
    seen = 0;
    repeat (40) begin tick(); if (f_out_valid) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("[TB] FAIL flush_no_valid: out_valid cycles %0d required 0", seen); end

    f3_32 = 3'b001; a32 = 32'd9; b32 = 32'd9;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (s_busy !== 1'b0 || s_in_ready !== 1'b1 || s_result !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_midcalc: busy=%b in_ready=%b result=%h required 0 1 0",
               s_busy, s_in_ready, s_result);
    end
    seen = 0;
    repeat (40) begin tick(); if (s_out_valid) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("[TB] FAIL reset_no_valid: out_valid cycles %0d required 0", seen); end
  endtask

  task automatic test_xlen8();
    logic [7:0] a, b, r, exp;
    int lat;
    bit spec;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 8; k++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        if (k == 0) b = 8'h00;
        if (k == 1) begin a = 8'h80; b = 8'hFF; end
        if (k == 2) a = 8'h80;
        do_op8(3'(f), a, b, r, lat);
        exp = ref8(3'(f), a, b);
        total++;
        if (r !== exp) begin
          bad++;
          $display("[TB] FAIL x8_f%0d a=%h b=%h: got %h required %h", f, a, b, r, exp);
        end
        spec = (f >= 4) && ((b == 8'h00) || ((f == 4 || f == 6) && a == 8'h80 && b == 8'hFF));
        total++;
        if (lat !== (spec ? 0 : 9)) begin
          bad++;
          $display("[TB] FAIL x8_lat_f%0d a=%h b=%h: got %0d required %0d", f, a, b, lat, spec ? 0 : 9);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush();
    test_xlen8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
